hdmi_out_pixel_reader: RTL and testbench

Read-side consumer of the HDMI-out prefetch FIFO. It generates the video raster timing (HS/VS/DE) and pops one FIFO word per active pixel through the rd_en/rd_vld handshake. The upstream frame writer tags the first pixel of every frame, and this block uses that tag to align the FIFO stream to the raster. It detects underflow and misalignment and recovers by flushing to the next frame-start tag. It sits between the FIFO read port and the HDMI transmitter's parallel RGB input.

---
 rtl/hdmi_out_pixel_reader_if.sv | 21 ++
 rtl/hdmi_out_pixel_reader.sv | 153 +++++++++++++++
 tb/tb_hdmi_out_pixel_reader.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_out_pixel_reader_if.sv
// Read-port handshake between the HDMI-out prefetch FIFO and its pixel reader.
// master = the reader (issues pops), slave = the FIFO (presents the head word).
interface hdmi_out_pixel_reader_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_vld;
  logic                  rd_en;

  modport master (
    output rd_en,
    input  rd_data,
    input  rd_vld
  );

  modport slave (
    input  rd_en,
    output rd_data,
    output rd_vld
  );
endinterface

// File: rtl/hdmi_out_pixel_reader.sv
// Raster timing generator that pops one FIFO word per active pixel, aligns the
// stream to frame-start tags and flushes to the next tag on underflow/misalignment.
module hdmi_out_pixel_reader #(
  parameter int          DATA_WIDTH = 32,
  parameter int          H_ACTIVE   = 1280,
  parameter int          H_FP       = 110,
  parameter int          H_SYNC     = 40,
  parameter int          H_BP       = 220,
  parameter int          V_ACTIVE   = 720,
  parameter int          V_FP       = 5,
  parameter int          V_SYNC     = 5,
  parameter int          V_BP       = 20,
  parameter bit          HS_POL     = 1'b1,
  parameter bit          VS_POL     = 1'b1,
  parameter logic [23:0] UF_COLOR   = 24'h000000
) (
  input  logic                           rd_clk,
  input  logic                           rd_rst,
  input  logic                           video_en,
  hdmi_out_pixel_reader_if.master        fifo,
  output logic                           hs_o,
  output logic                           vs_o,
  output logic                           de_o,
  output logic [23:0]                    rgb_o,
  output logic                           frame_start,
  output logic                           underflow,
  output logic                           misalign,
  output logic [15:0]                    err_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SYNC_SEARCH = 2'd1,
    RUN         = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [HW-1:0]   h_cnt;
  logic [VW-1:0]   v_cnt;
  logic            active;
  logic            sof_pos;
  logic            in_hs;
  logic            in_vs;
  logic            tag;
  logic            rd_en_c;
  logic            take_pix;
  logic            uf_ev;
  logic            mis_ev;
  logic            fs_nxt;
  logic            unused_rd_bits;

  function automatic logic [15:0] sat_inc(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  assign active         = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign sof_pos        = (h_cnt == '0) && (v_cnt == '0);
  assign in_hs          = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign in_vs          = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  assign tag            = fifo.rd_data[DATA_WIDTH-1];
  assign unused_rd_bits = ^fifo.rd_data[DATA_WIDTH-2:24];

  always_ff @(posedge rd_clk) begin
    if (rd_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Stopping the video at a frame boundary overrides every other transition.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:        if (video_en) state_nxt = SYNC_SEARCH;
      SYNC_SEARCH: if (sof_pos && fifo.rd_vld && tag) state_nxt = RUN;
      RUN:         if (active && (!fifo.rd_vld || (tag != sof_pos))) state_nxt = SYNC_SEARCH;
      default:     state_nxt = IDLE;
    endcase
    if (sof_pos && !video_en) state_nxt = IDLE;
  end

  // An early tagged word is never popped so it can open the next frame.
  always_comb begin
    rd_en_c  = 1'b0;
    take_pix = 1'b0;
    uf_ev    = 1'b0;
    mis_ev   = 1'b0;
    unique case (state)
      SYNC_SEARCH: begin
        if (fifo.rd_vld && !tag) rd_en_c = 1'b1;
        if (sof_pos && video_en && fifo.rd_vld && tag) begin
          rd_en_c  = 1'b1;
          take_pix = 1'b1;
        end
      end
      RUN: if (active) begin
        rd_en_c = !(fifo.rd_vld && tag && !sof_pos);
        if (!fifo.rd_vld)         uf_ev    = 1'b1;
        else if (tag != sof_pos)  mis_ev   = 1'b1;
        else                      take_pix = 1'b1;
      end
      default: ;
    endcase
  end

  assign fifo.rd_en = rd_en_c && !rd_rst;
  assign fs_nxt     = sof_pos && ((state == RUN) || (state_nxt == RUN));

  // Stage boundary: raster position -> registered video outputs.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hs_o        <= ~HS_POL;
      vs_o        <= ~VS_POL;
      de_o        <= 1'b0;
      rgb_o       <= 24'h000000;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      misalign    <= 1'b0;
      err_cnt     <= 16'h0000;
    end else begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
      hs_o        <= in_hs ? HS_POL : ~HS_POL;
      vs_o        <= in_vs ? VS_POL : ~VS_POL;
      de_o        <= active;
      rgb_o       <= take_pix ? fifo.rd_data[23:0] : UF_COLOR;
      frame_start <= fs_nxt;
      underflow   <= underflow | uf_ev;
      misalign    <= misalign | mis_ev;
      if (uf_ev || mis_ev) err_cnt <= sat_inc(err_cnt);
    end
  end

endmodule

// File: tb/tb_hdmi_out_pixel_reader.sv
// Bench for hdmi_out_pixel_reader: queue-backed FIFO, frame-level reference model,
// directed scenarios with literal expectations and a randomized soak.
module tb_hdmi_out_pixel_reader;
  localparam int DW = 32;
  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int PX = HA * VA;

  logic        rd_clk = 1'b0;
  logic        rd_rst = 1'b1;
  logic        video_en = 1'b0;
  logic        hs_o, vs_o, de_o, frame_start, underflow, misalign;
  logic [23:0] rgb_o;
  logic [15:0] err_cnt;

  hdmi_out_pixel_reader_if #(.DATA_WIDTH(DW)) fifo ();

  hdmi_out_pixel_reader #(
    .DATA_WIDTH(DW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .UF_COLOR(24'h000000)
  ) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .video_en(video_en), .fifo(fifo),
    .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o), .rgb_o(rgb_o),
    .frame_start(frame_start), .underflow(underflow), .misalign(misalign),
    .err_cnt(err_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef enum int {M_IDLE, M_SEARCH, M_RUN} mode_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] q[$];
  bit          refill = 1'b0;
  logic [31:0] tag_word = 32'h8000_0000;
  mode_t       m_mode = M_IDLE;
  int          m_t = 0;
  bit          mdl_ok = 1'b0;
  logic        e_hs, e_vs, e_de, e_fs, e_uf, e_mis;
  logic [23:0] e_rgb;
  logic [15:0] e_err;
  int          dut_pops = 0;
  int          dut_junk_pops = 0;
  bit          any_rd_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input int junk, input int len, input bit rnd);
    for (int i = 0; i < junk; i++) q.push_back({8'h00, 24'($urandom)});
    q.push_back(tag_word);
    for (int i = 1; i < len; i++) q.push_back(rnd ? {8'h00, 24'($urandom)} : 32'(i));
  endtask

  // One clock: check registered outputs, drive inputs, predict rd_en and next outputs.
  task automatic step(input bit r, input bit ve, input bit gate);
    int h, v;
    bit act, sof, vld, tg, pop, good, uf_ev, mis_ev, en;
    mode_t nm;
    logic [31:0] d;
    @(negedge rd_clk);
    if (mdl_ok)
      chk("outputs", {18'd0, hs_o, vs_o, de_o, rgb_o, frame_start, underflow, misalign, err_cnt},
                     {18'd0, e_hs, e_vs, e_de, e_rgb, e_fs, e_uf, e_mis, e_err});
    if (refill && q.size() < 2 * PX) push_frame(0, PX, 1'b0);
    rd_rst        = r;
    video_en      = ve;
    fifo.rd_vld   = gate && (q.size() > 0);
    fifo.rd_data  = (q.size() > 0) ? q[0] : $urandom;
    #1;
    vld = fifo.rd_vld;
    d   = fifo.rd_data;
    tg  = d[DW-1];
    pop = 0; good = 0; uf_ev = 0; mis_ev = 0; en = 0;
    if (r) begin
      m_mode = M_IDLE; m_t = 0; mdl_ok = 1'b1;
      e_hs = 0; e_vs = 0; e_de = 0; e_rgb = 24'h0; e_fs = 0; e_uf = 0; e_mis = 0; e_err = 16'h0;
    end else begin
      h   = m_t % HT;
      v   = m_t / HT;
      act = (h < HA) && (v < VA);
      sof = (m_t == 0);
      nm  = m_mode;
      case (m_mode)
        M_IDLE:   if (ve) nm = M_SEARCH;
        M_SEARCH: begin
          if (vld && !tg) pop = 1;
          else if (vld && sof && ve) begin pop = 1; good = 1; nm = M_RUN; end
        end
        M_RUN: if (act) begin
          if (!vld)          begin uf_ev = 1; nm = M_SEARCH; end
          else if (tg == sof) begin good = 1; pop = 1; end
          else               begin mis_ev = 1; pop = !tg; nm = M_SEARCH; end
        end
        default: ;
      endcase
      if (sof && !ve) nm = M_IDLE;
      en    = pop || uf_ev;
      e_hs  = (h >= HA + HF) && (h < HA + HF + HS);
      e_vs  = (v >= VA + VF) && (v < VA + VF + VS);
      e_de  = act;
      e_rgb = good ? d[23:0] : 24'h0;
      e_fs  = sof && (m_mode == M_RUN || nm == M_RUN);
      e_uf  = e_uf | uf_ev;
      e_mis = e_mis | mis_ev;
      if ((uf_ev || mis_ev) && e_err != 16'hFFFF) e_err = e_err + 16'd1;
      m_mode = nm;
      m_t    = (m_t + 1) % FT;
    end
    chk("rd_en", 64'(fifo.rd_en), 64'(en));
    if (fifo.rd_en) any_rd_en = 1'b1;
    if (fifo.rd_en && vld) begin
      dut_pops++;
      if (!tg) dut_junk_pops++;
    end
    if (pop) void'(q.pop_front());
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b1);
    chk("rst_rd_en", 64'(fifo.rd_en), 64'd0);
    step(1'b0, 1'b0, 1'b1);
    chk("rst_outputs", {18'd0, hs_o, vs_o, de_o, rgb_o, frame_start, underflow, misalign, err_cnt}, 64'd0);
  endtask

  int  hs_n, de_n, rgb_nz, fs_seen, cap_n, pops_at_fs, drop_i, rec_n, jp0, prev_jp, found;
  bit  dropped, recover, mis_seen, done, g, ve_r;

  initial begin
    fifo.rd_vld  = 1'b0;
    fifo.rd_data = '0;

    // Idle raster: timing only, no pops even with data waiting.
    q.delete(); push_frame(0, PX, 1'b0); refill = 1'b0;
    do_reset();
    hs_n = 0; de_n = 0; rgb_nz = 0; any_rd_en = 1'b0;
    for (int i = 0; i < 96; i++) begin
      step(1'b0, 1'b0, 1'b1);
      hs_n += int'(hs_o); de_n += int'(de_o);
      if (rgb_o != 24'h0) rgb_nz++;
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
    chk("t1_hs_count", 64'(hs_n), 64'd24);
    chk("t1_de_count", 64'(de_n), 64'd24);
    chk("t1_rd_en_never", 64'(any_rd_en), 64'd0);
    chk("t1_rgb_zero", 64'(rgb_nz), 64'd0);

    // Clean streaming: pixels 0..11 in raster order, 12 pops per frame.
    do_reset();
    q.delete(); tag_word = 32'h8000_0000; refill = 1'b1;
    fs_seen = 0; cap_n = 0; pops_at_fs = 0;
    for (int i = 0; i < 200 && fs_seen < 2; i++) begin
      step(1'b0, 1'b1, 1'b1);
      if (frame_start) begin
        fs_seen++;
        if (fs_seen == 1) pops_at_fs = dut_pops;
        else chk("t2_pops_per_frame", 64'(dut_pops - pops_at_fs), 64'd12);
      end
      if (de_o && fs_seen == 1 && cap_n < PX) begin
        chk($sformatf("t2_pix%0d", cap_n), 64'(rgb_o), 64'(cap_n));
        chk($sformatf("t2_fs%0d", cap_n), 64'(frame_start), 64'(cap_n == 0));
        cap_n++;
      end
    end
    chk("t2_frames_seen", 64'(fs_seen), 64'd2);

    // Underflow at the 5th pixel of the first running frame.
    do_reset();
    q.delete(); refill = 1'b1;
    dropped = 0; recover = 0; rec_n = 0; drop_i = -10;
    for (int i = 0; i < 300 && rec_n == 0; i++) begin
      g = !(m_mode == M_RUN && m_t == HT && !dropped);
      step(1'b0, 1'b1, g);
      if (!g) begin dropped = 1; drop_i = i; end
      if (dropped && i == drop_i + 1) begin
        chk("t3_uf_rgb", 64'(rgb_o), 64'd0);
        chk("t3_uf_de", 64'(de_o), 64'd1);
        chk("t3_underflow", 64'(underflow), 64'd1);
        chk("t3_err_cnt", 64'(err_cnt), 64'd1);
      end else if (dropped && i > drop_i + 1) begin
        if (frame_start) recover = 1;
        else if (recover && de_o) begin
          chk("t3_realign_pix1", 64'(rgb_o), 64'd1);
          rec_n = 1;
        end
      end
    end
    chk("t3_recovered", 64'(rec_n), 64'd1);
    chk("t3_err_final", 64'(err_cnt), 64'd1);
    chk("t3_no_misalign", 64'(misalign), 64'd0);

    // Early tag at pixel 7: misalign, tag kept for the next frame.
    do_reset();
    q.delete(); refill = 1'b0; tag_word = 32'h80AB_CDEF;
    push_frame(0, 6, 1'b0);
    for (int k = 0; k < 3; k++) push_frame(0, PX, 1'b0);
    refill = 1'b1;
    mis_seen = 0; done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      step(1'b0, 1'b1, 1'b1);
      if (misalign && !mis_seen) begin
        mis_seen = 1;
        chk("t4_mis_rgb", 64'(rgb_o), 64'd0);
        chk("t4_mis_de", 64'(de_o), 64'd1);
        chk("t4_err_cnt", 64'(err_cnt), 64'd1);
        chk("t4_no_underflow", 64'(underflow), 64'd0);
      end else if (mis_seen && frame_start) begin
        chk("t4_next_sof_rgb", 64'(rgb_o), 64'h00AB_CDEF);
        done = 1;
      end
    end
    chk("t4_done", 64'(done), 64'd1);

    // Reset pulsed mid-line while running.
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      if (m_mode == M_RUN && m_t == HT + 2) found = 1;
      else step(1'b0, 1'b1, 1'b1);
    end
    chk("t6_reached_run", 64'(found), 64'd1);
    step(1'b1, 1'b1, 1'b1);
    chk("t6_rd_en_in_rst", 64'(fifo.rd_en), 64'd0);
    step(1'b0, 1'b1, 1'b1);
    chk("t6_outputs_reset", {18'd0, hs_o, vs_o, de_o, rgb_o, frame_start, underflow, misalign, err_cnt}, 64'd0);
    chk("t6_idle_no_pop", 64'(fifo.rd_en), 64'd0);
    step(1'b0, 1'b1, 1'b1);
    chk("t6_raster_restart_de", 64'(de_o), 64'd1);
    chk("t6_raster_restart_hs", 64'(hs_o), 64'd0);

    // Three junk words ahead of the tag while searching.
    do_reset();
    q.delete(); refill = 1'b0; tag_word = 32'h8012_3456;
    q.push_back(32'h0000_0011); q.push_back(32'h0000_0022); q.push_back(32'h0000_0033);
    push_frame(0, PX, 1'b0); push_frame(0, PX, 1'b0);
    refill = 1'b1;
    jp0 = dut_junk_pops; found = 0;
    for (int i = 0; i < 120 && found == 0; i++) begin
      prev_jp = dut_junk_pops;
      step(1'b0, 1'b1, 1'b1);
      if (frame_start) begin
        found = 1;
        chk("t5_junk_popped", 64'(prev_jp - jp0), 64'd3);
        chk("t5_sof_rgb", 64'(rgb_o), 64'h0012_3456);
      end
    end
    chk("t5_fs_seen", 64'(found), 64'd1);

    // Randomized soak: gaps, junk, short/long frames, video_en toggles.
    do_reset();
    q.delete(); refill = 1'b0; ve_r = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (q.size() < 30) begin
        tag_word = {8'h80, 24'($urandom)};
        push_frame(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                   ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 14)) : PX, 1'b1);
      end
      if ($urandom_range(0, 149) == 0) ve_r = !ve_r;
      step(1'b0, ve_r, $urandom_range(0, 15) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
